// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    // Controller states; the unused encoding 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: clog2 of the operand width, never less than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Existing single-bit full adder shared by the serial controller.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic Y,
    output logic cout
);

    // Sum and carry of one bit position.
    always_comb begin
        Y    = A ^ B ^ cin;
        cout = (A & B) | (cin & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder sequenced over WIDTH clocks, LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] ybit;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_y;
    logic             fa_cout;
    logic             last;

    full_adder u_fa (
        .A    (opa[0]),
        .B    (opb[0]),
        .cin  (carry),
        .Y    (fa_y),
        .cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Result shift register after this bit: new bit enters at the MSB end.
    // Built with a one-hot mask so WIDTH=1 needs no zero-width slice.
    always_comb begin
        ybit            = '0;
        ybit[WIDTH-1]   = fa_y;
        res_nx          = (res >> 1) | ybit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status decode.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand load, per-bit shift/carry update and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        res   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    res   <= res_nx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_nx;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=1, 4 and 8.
module tb_serial_add_ctrl;

    typedef struct {
        logic       done;
        logic       busy;
        logic       cout;
        logic [7:0] sum;
    } obs_t;

    typedef struct {
        int         w;
        logic [8:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1, cin1, a1, b1, sum1, cout1, busy1, done1;
    logic       start4, cin4, cout4, busy4, done4;
    logic [3:0] a4, b4, sum4;
    logic       start8, cin8, cout8, busy8, done8;
    logic [7:0] a8, b8, sum8;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
    );
    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );
    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    function automatic obs_t sample(input int w);
        obs_t o;
        case (w)
            1: begin o.done = done1; o.busy = busy1; o.cout = cout1; o.sum = {7'd0, sum1}; end
            4: begin o.done = done4; o.busy = busy4; o.cout = cout4; o.sum = {4'd0, sum4}; end
            default: begin o.done = done8; o.busy = busy8; o.cout = cout8; o.sum = sum8; end
        endcase
        return o;
    endfunction

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic st);
        case (w)
            1: begin a1 = a[0]; b1 = b[0]; cin1 = c; start1 = st; end
            4: begin a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = st; end
            default: begin a8 = a; b8 = b; cin8 = c; start8 = st; end
        endcase
    endtask

    // One addition: push expectation, pulse start, watch held outputs, pop on done.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic poke, input string tag);
        obs_t       o;
        exp_t       e;
        logic [7:0] hs, es;
        logic       hc, ec;
        int         n;
        bit         got;
        o  = sample(w);
        hs = o.sum;
        hc = o.cout;
        e.w = w;
        e.v = 9'(a) + 9'(b) + 9'(c);
        q.push_back(e);
        drive(w, a, b, c, 1'b1);
        n   = 0;
        got = 0;
        while (!got && n <= w + 3) begin
            @(negedge clk);
            n++;
            o = sample(w);
            if (o.done) begin
                got = 1;
            end else begin
                total++;
                if (o.busy !== 1'b1 || o.sum !== hs || o.cout !== hc) begin
                    bad++;
                    $display("FAIL %s_run n=%0d got busy=%b sum=%0d cout=%b need busy=1 sum=%0d cout=%b",
                             tag, n, o.busy, o.sum, o.cout, hs, hc);
                end
                drive(w, 8'($urandom), 8'($urandom), 1'($urandom), poke && n == 2);
            end
        end
        total++;
        if (!got || n != w + 1) begin
            bad++;
            $display("FAIL %s_latency got done=%b after %0d edges need %0d", tag, got, n, w + 1);
        end
        e  = q.pop_front();
        es = 8'(e.v & ((9'd1 << e.w) - 9'd1));
        ec = e.v[e.w];
        if (got) begin
            total++;
            if (o.sum !== es || o.cout !== ec || o.busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_result got sum=%0d cout=%b busy=%b need sum=%0d cout=%b busy=1",
                         tag, o.sum, o.cout, o.busy, es, ec);
            end
        end
        drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        @(negedge clk);
        o = sample(w);
        total++;
        if (o.done !== 1'b0 || o.busy !== 1'b0 || o.sum !== es || o.cout !== ec) begin
            bad++;
            $display("FAIL %s_after got done=%b busy=%b sum=%0d cout=%b need done=0 busy=0 sum=%0d cout=%b",
                     tag, o.done, o.busy, o.sum, o.cout, es, ec);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        drive(1, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                o = sample(k == 0 ? 1 : (k == 1 ? 4 : 8));
                total++;
                if (o.sum !== 8'd0 || o.cout !== 1'b0 || o.busy !== 1'b0 || o.done !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_idle cyc=%0d inst=%0d got sum=%0d cout=%b busy=%b done=%b need all 0",
                             i, k, o.sum, o.cout, o.busy, o.done);
                end
            end
        end
    endtask

    task automatic test_basic();
        run_op(4, 8'd9, 8'd7, 1'b0, 1'b1, "basic_9_7");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                bad++;
                $display("FAIL ignored_start cyc=%0d got done=%b busy=%b need 0 0", i, done4, busy4);
            end
        end
    endtask

    task automatic test_hold();
        run_op(4, 8'd15, 8'd15, 1'b1, 1'b0, "max");
        run_op(4, 8'd3, 8'd4, 1'b1, 1'b0, "hold_3_4");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   gap;
        logic [7:0] exps [3] = '{8'd3, 8'd3, 8'd7};
        for (int i = 0; i < 3; i++) begin
            e.w = 4;
            e.v = 9'(exps[i]);
            q.push_back(e);
        end
        drive(4, 8'd1, 8'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (i == 1 && gap == 2) drive(4, 8'd5, 8'd2, 1'b0, 1'b1);
            end while (done4 !== 1'b1 && gap < 12);
            total++;
            if (done4 !== 1'b1 || (i > 0 && gap != 6) || (i == 0 && gap != 5)) begin
                bad++;
                $display("FAIL b2b_gap op=%0d got done=%b gap=%0d need done=1 gap=%0d",
                         i, done4, gap, (i == 0) ? 5 : 6);
            end
            e = q.pop_front();
            total++;
            if (sum4 !== e.v[3:0] || cout4 !== e.v[4]) begin
                bad++;
                $display("FAIL b2b_result op=%0d got sum=%0d cout=%b need sum=%0d cout=%b",
                         i, sum4, cout4, e.v[3:0], e.v[4]);
            end
        end
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop got busy=%b done=%b need 0 0", busy4, done4);
        end
    endtask

    task automatic test_abort();
        drive(4, 8'd6, 8'd5, 1'b0, 1'b1);
        @(negedge clk);
        drive(4, 8'd6, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (sum4 !== 4'd0 || cout4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_clear got sum=%0d cout=%b busy=%b done=%b need all 0",
                     sum4, cout4, busy4, done4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || sum4 !== 4'd0) begin
                bad++;
                $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b sum=%0d need 0 0 0",
                         i, done4, busy4, sum4);
            end
        end
        run_op(4, 8'd2, 8'd2, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_widths();
        run_op(1, 8'd1, 8'd1, 1'b1, 1'b0, "w1_111");
        run_op(1, 8'd1, 8'd0, 1'b0, 1'b1, "w1_100");
        run_op(8, 8'd200, 8'd100, 1'b0, 1'b0, "w8_200_100");
        run_op(8, 8'd255, 8'd255, 1'b1, 1'b0, "w8_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_op(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom), 1'b0, "rnd4");
            run_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom), 1'b0, "rnd8");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_abort();
        test_widths();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
